// File: rtl/dendrite_compartment.sv
// Dendritic compartment: masked synaptic current sum, leaky saturating integrator, spike handshake, refractory hold.
// Latency: synapse input -> sum_r 1 cycle, -> vmem 2 cycles; cfg_dout trails cfg_din by CFG_BITS shifts.
// Backpressure: a raised spike waits in FIRE (vmem frozen, inputs ignored) until spike_ready is sampled high.
//
// Ports:
//   clk, reset (async, active-low)
//   cfg_en / cfg_din / cfg_dout : serial config chain {enable, leak_shift[3:0], threshold[WIDTH-1:0]}, MSB first
//   syn_current / syn_valid     : N_SYN signed currents, synapse i at [i*WIDTH +: WIDTH]; invalid ones count as 0
//   vmem                        : registered signed membrane potential
//   spike_valid / spike_ready   : spike event handshake to the neuron
//   sat_flag / sat_clear        : sticky saturation indicator and its clear (clear wins over set)

package fp;
  localparam int WORD_LENGTH = 16;
endpackage

module dendrite_compartment #(
  parameter int N_SYN          = 4,
  parameter int WIDTH          = fp::WORD_LENGTH,
  parameter int REFRACT_CYCLES = 4,
  parameter int CFG_BITS       = WIDTH + 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cfg_en,
  input  logic                     cfg_din,
  output logic                     cfg_dout,
  input  logic [N_SYN*WIDTH-1:0]   syn_current,
  input  logic [N_SYN-1:0]         syn_valid,
  output logic [WIDTH-1:0]         vmem,
  output logic                     spike_valid,
  input  logic                     spike_ready,
  output logic                     sat_flag,
  input  logic                     sat_clear
);

  // Sum width leaves headroom for N_SYN full-scale currents plus a guard bit.
  localparam int SW = WIDTH + $clog2(N_SYN) + 1;
  localparam int VW = WIDTH + 2;
  localparam int CW = (REFRACT_CYCLES > 1) ? $clog2(REFRACT_CYCLES + 1) : 1;

  localparam logic [WIDTH-1:0] VMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] VMIN = {1'b1, {(WIDTH-1){1'b0}}};

  localparam logic [1:0] ST_INTEG   = 2'd0;
  localparam logic [1:0] ST_FIRE    = 2'd1;
  localparam logic [1:0] ST_REFRACT = 2'd2;

  logic [CFG_BITS-1:0] chain;
  logic                enable;
  logic [3:0]          leak_shift;
  logic [WIDTH-1:0]    threshold;

  logic [1:0]          state;
  logic [CW-1:0]       refr_cnt;
  logic [WIDTH-1:0]    sum_r;

  // Config fields are decoded straight off the chain, so they change while shifting.
  assign enable     = chain[CFG_BITS-1];
  assign leak_shift = chain[CFG_BITS-2 -: 4];
  assign threshold  = chain[WIDTH-1:0];
  assign cfg_dout   = chain[CFG_BITS-1];

  // Stage 1: masked sum at full precision, then clamp to WIDTH.
  logic signed [SW-1:0] sum_wide;
  logic                 sum_fits;
  logic [WIDTH-1:0]     sum_sat;

  always_comb begin
    sum_wide = '0;
    for (int i = 0; i < N_SYN; i++) begin
      if (syn_valid[i]) begin
        sum_wide = sum_wide + {{(SW-WIDTH){syn_current[i*WIDTH+WIDTH-1]}},
                               syn_current[i*WIDTH +: WIDTH]};
      end
    end
  end

  // Value fits when all bits from the WIDTH sign position upward agree.
  assign sum_fits = (&sum_wide[SW-1:WIDTH-1]) | ~(|sum_wide[SW-1:WIDTH-1]);
  assign sum_sat  = sum_fits ? sum_wide[WIDTH-1:0] : (sum_wide[SW-1] ? VMIN : VMAX);

  // Stage 2: leak and accumulate. leak_raw is kept in its own signed net so
  // the shift stays arithmetic regardless of the surrounding mux.
  logic signed [VW-1:0] vmem_x;
  logic signed [VW-1:0] sum_x;
  logic signed [VW-1:0] leak_raw;
  logic signed [VW-1:0] leak;
  logic signed [VW-1:0] nxt_wide;
  logic                 nxt_fits;
  logic [WIDTH-1:0]     nxt;
  logic                 fire_now;
  logic                 sat_set;

  assign vmem_x   = {{2{vmem[WIDTH-1]}}, vmem};
  assign sum_x    = {{2{sum_r[WIDTH-1]}}, sum_r};
  assign leak_raw = vmem_x >>> leak_shift;
  assign leak     = (leak_shift == 4'd0) ? '0 : leak_raw;
  assign nxt_wide = vmem_x - leak + sum_x;
  assign nxt_fits = (&nxt_wide[VW-1:WIDTH-1]) | ~(|nxt_wide[VW-1:WIDTH-1]);
  assign nxt      = nxt_fits ? nxt_wide[WIDTH-1:0] : (nxt_wide[VW-1] ? VMIN : VMAX);
  assign fire_now = ($signed(nxt) >= $signed(threshold));

  // A vmem clip only counts when the clipped value is actually loaded.
  assign sat_set  = ~sum_fits | (~nxt_fits & enable & (state == ST_INTEG));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      chain       <= '0;
      sum_r       <= '0;
      vmem        <= '0;
      state       <= ST_INTEG;
      refr_cnt    <= '0;
      spike_valid <= 1'b0;
      sat_flag    <= 1'b0;
    end else begin
      if (cfg_en) begin
        chain <= {chain[CFG_BITS-2:0], cfg_din};
      end

      sum_r <= sum_sat;

      if (sat_clear) begin
        sat_flag <= 1'b0;
      end else if (sat_set) begin
        sat_flag <= 1'b1;
      end

      if (!enable) begin
        // Disabled compartment: drop any pending spike and stay cleared.
        state       <= ST_INTEG;
        spike_valid <= 1'b0;
        vmem        <= '0;
        refr_cnt    <= '0;
      end else begin
        case (state)
          ST_INTEG: begin
            vmem <= nxt;
            if (fire_now) begin
              state       <= ST_FIRE;
              spike_valid <= 1'b1;
            end
          end
          ST_FIRE: begin
            if (spike_ready) begin
              vmem        <= '0;
              spike_valid <= 1'b0;
              if (REFRACT_CYCLES > 0) begin
                state    <= ST_REFRACT;
                refr_cnt <= CW'(REFRACT_CYCLES);
              end else begin
                state <= ST_INTEG;
              end
            end
          end
          ST_REFRACT: begin
            vmem <= '0;
            if (refr_cnt == CW'(1)) begin
              state    <= ST_INTEG;
              refr_cnt <= '0;
            end else begin
              refr_cnt <= refr_cnt - CW'(1);
            end
          end
          default: begin
            state       <= ST_INTEG;
            spike_valid <= 1'b0;
            vmem        <= '0;
            refr_cnt    <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dendrite_compartment.sv
// Bench for dendrite_compartment: a driver issues stimulus and pushes the
// expected post-edge outputs from an arithmetic reference model into a queue;
// a monitor pops and compares on every falling edge.
module tb_dendrite_compartment;
  localparam int W  = 16;
  localparam int N  = 4;
  localparam int RC = 4;
  localparam int CB = W + 5;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             cfg_en = 1'b0;
  logic             cfg_din = 1'b0;
  logic             cfg_dout;
  logic [N*W-1:0]   syn_current = '0;
  logic [N-1:0]     syn_valid = '0;
  logic [W-1:0]     vmem;
  logic             spike_valid;
  logic             spike_ready = 1'b0;
  logic             sat_flag;
  logic             sat_clear = 1'b0;

  always #5 clk = ~clk;

  dendrite_compartment #(.N_SYN(N), .WIDTH(W), .REFRACT_CYCLES(RC), .CFG_BITS(CB)) dut (
    .clk(clk), .reset(reset), .cfg_en(cfg_en), .cfg_din(cfg_din), .cfg_dout(cfg_dout),
    .syn_current(syn_current), .syn_valid(syn_valid), .vmem(vmem),
    .spike_valid(spike_valid), .spike_ready(spike_ready),
    .sat_flag(sat_flag), .sat_clear(sat_clear)
  );

  typedef struct {
    int vmem;
    bit sv;
    bit sat;
    bit dout;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;

  // Stimulus for the next cycle
  bit       s_rst = 1'b0;
  bit       s_ce  = 1'b0;
  bit       s_din = 1'b0;
  int       s_cur[N];
  bit [N-1:0] s_vld = '0;
  bit       s_rdy = 1'b0;
  bit       s_clr = 1'b0;

  // Reference model: mode 0 integrating, 1 spike waiting, 2 refractory with m_left cycles to go
  bit [CB-1:0] m_chain = '0;
  int m_sum = 0, m_vmem = 0, m_mode = 0, m_left = 0;
  bit m_sv = 1'b0, m_sat = 1'b0;

  function automatic int clamp(input int v, output bit clipped);
    int r;
    r = v;
    if (v > 32767) r = 32767;
    if (v < -32768) r = -32768;
    clipped = (r != v);
    return r;
  endfunction

  function automatic bit [CB-1:0] mk(input bit en, input int sh, input int thr);
    bit [3:0]   s4;
    bit [W-1:0] t;
    s4 = sh[3:0];
    t  = thr[W-1:0];
    return {en, s4, t};
  endfunction

  task automatic chk(input string nm, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s t=%0t actual=%0d required=%0d", nm, $time, act, req);
    end
  endtask

  task automatic tick();
    exp_t e;
    bit   en, c1, c2;
    int   sh, thr, raw, s, leak, n;
    @(negedge clk);
    #1;
    reset   = s_rst;
    cfg_en  = s_ce;
    cfg_din = s_din;
    for (int i = 0; i < N; i++) syn_current[i*W +: W] = W'(s_cur[i]);
    syn_valid   = s_vld;
    spike_ready = s_rdy;
    sat_clear   = s_clr;

    if (!s_rst) begin
      m_chain = '0; m_sum = 0; m_vmem = 0; m_mode = 0; m_left = 0; m_sv = 0; m_sat = 0;
    end else begin
      en  = m_chain[CB-1];
      sh  = int'(m_chain[CB-2 -: 4]);
      thr = int'($signed(m_chain[W-1:0]));
      raw = 0;
      for (int i = 0; i < N; i++) if (s_vld[i]) raw += s_cur[i];
      s    = clamp(raw, c1);
      leak = (sh == 0) ? 0 : (m_vmem >>> sh);
      n    = clamp(m_vmem - leak + m_sum, c2);
      if (s_clr) m_sat = 0;
      else if (c1 || (c2 && en && m_mode == 0)) m_sat = 1;
      if (!en) begin
        m_mode = 0; m_sv = 0; m_vmem = 0; m_left = 0;
      end else if (m_mode == 0) begin
        m_vmem = n;
        if (n >= thr) begin m_mode = 1; m_sv = 1; end
      end else if (m_mode == 1) begin
        if (s_rdy) begin
          m_vmem = 0; m_sv = 0; m_left = RC;
          m_mode = (RC > 0) ? 2 : 0;
        end
      end else begin
        m_vmem = 0;
        m_left = m_left - 1;
        if (m_left == 0) m_mode = 0;
      end
      m_sum = s;
      if (s_ce) m_chain = {m_chain[CB-2:0], s_din};
    end
    e.vmem = m_vmem; e.sv = m_sv; e.sat = m_sat; e.dout = m_chain[CB-1];
    q.push_back(e);
  endtask

  task automatic load_cfg(input bit [CB-1:0] word);
    for (int b = CB - 1; b >= 0; b--) begin
      s_ce  = 1'b1;
      s_din = word[b];
      tick();
    end
    s_ce = 1'b0;
  endtask

  task automatic set_cur(input int a, input int b, input int c, input int d, input bit [N-1:0] v);
    s_cur[0] = a; s_cur[1] = b; s_cur[2] = c; s_cur[3] = d; s_vld = v;
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("vmem", int'($signed(vmem)), e.vmem);
        chk("spike_valid", int'(spike_valid), int'(e.sv));
        chk("sat_flag", int'(sat_flag), int'(e.sat));
        chk("cfg_dout", int'(cfg_dout), int'(e.dout));
      end
    end
  end

  initial begin
    set_cur(0, 0, 0, 0, 4'b0000);
    // reset state
    s_rst = 1'b0; repeat (2) tick();
    s_rst = 1'b1; tick();

    // config word shifted twice: second pass replays the first on cfg_dout
    load_cfg(mk(1, 3, 1000));
    load_cfg(mk(1, 3, 1000));

    // integrate 250/cycle to threshold 1000, hold spike 5+ cycles, accept, refractory
    load_cfg(mk(0, 0, 1000));
    load_cfg(mk(1, 0, 1000));
    set_cur(100, 200, -50, 0, 4'b0111);
    s_rdy = 1'b0; repeat (10) tick();
    s_rdy = 1'b1; tick();
    s_rdy = 1'b0; repeat (8) tick();
    set_cur(0, 0, 0, 0, 4'b0000); repeat (3) tick();

    // leak decay from a single 80 pulse
    load_cfg(mk(0, 3, 32767));
    load_cfg(mk(1, 3, 32767));
    set_cur(80, 0, 0, 0, 4'b0001); tick();
    set_cur(0, 0, 0, 0, 4'b0000); repeat (12) tick();

    // positive saturation and spike at full scale
    load_cfg(mk(1, 0, 32767));
    set_cur(32767, 32767, 32767, 32767, 4'b1111);
    repeat (4) tick();
    s_rdy = 1'b1; tick(); s_rdy = 1'b0;
    // negative saturation, no spike; clear while still clipping, then clear when quiet
    set_cur(-32768, -32768, -32768, -32768, 4'b1111);
    repeat (8) tick();
    s_clr = 1'b1; tick(); s_clr = 1'b0; tick();
    set_cur(0, 0, 0, 0, 4'b0000); repeat (2) tick();
    s_clr = 1'b1; tick(); s_clr = 1'b0; repeat (2) tick();

    // enable cleared mid-FIRE via one extra config shift
    load_cfg(mk(1, 0, 500));
    set_cur(300, 0, 0, 0, 4'b0001); repeat (4) tick();
    set_cur(0, 0, 0, 0, 4'b0000);
    s_ce = 1'b1; s_din = 1'b0; tick(); s_ce = 1'b0;
    repeat (3) tick();

    // reset dropped during REFRACT
    load_cfg(mk(1, 0, 500));
    set_cur(300, 0, 0, 0, 4'b0001); repeat (4) tick();
    s_rdy = 1'b1; tick(); s_rdy = 1'b0; repeat (2) tick();
    s_rst = 1'b0; tick();
    s_rst = 1'b1; repeat (3) tick();

    // randomized traffic
    load_cfg(mk(1, $urandom_range(0, 4), $urandom_range(200, 3000)));
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < N; i++) begin
        s_cur[i] = int'($urandom_range(0, 600)) - 200;
        if ($urandom_range(0, 19) == 0) s_cur[i] = ($urandom_range(0, 1) == 0) ? 32767 : -32768;
      end
      s_vld = N'($urandom_range(0, 15));
      s_rdy = ($urandom_range(0, 3) != 0);
      s_clr = ($urandom_range(0, 15) == 0);
      tick();
    end
    set_cur(0, 0, 0, 0, 4'b0000); s_rdy = 1'b0; s_clr = 1'b0;
    tick();

    @(negedge clk);
    @(negedge clk);
    #2;
    chk("drain", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
